memory_sequencer: RTL

Multi-cycle sequencer that shares the core's single memory port between instruction fetch and data load/store. It fetches an instruction and holds it stable while `control_logic_unit` decodes it. It then performs the data access requested by `read_mem`/`write_mem`/`load_byte`/`store_byte` and pulses `cpu_en` for one cycle to commit PC and register-file updates. It sits between the core datapath and the external memory bus.

---
 rtl/memory_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/memory_sequencer.sv
// memory_sequencer: shares the single memory port between instruction fetch
// and data load/store. It fetches an instruction, holds it while the core
// decodes it, performs the requested data access and then issues a one-cycle
// commit strobe. All bus outputs are decoded from the registered state only.
//
//   state  | meaning
//   IDLE   | just out of reset, fetch starts next cycle
//   FETCH  | instruction read on the bus, waiting for mem_ack
//   EXEC   | one idle-bus cycle while the held instruction is decoded
//   DATA   | load/store on the bus, waiting for mem_ack
//   COMMIT | cpu_en high for one cycle, then the next fetch
//   ERROR  | misaligned access or ack timeout; left only through reset
module memory_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] pc,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] data_addr,
  input  logic [31:0] store_data,
  output logic [31:0] instruction,
  output logic [31:0] load_data,
  output logic        cpu_en,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_COMMIT,
    S_ERROR
  } state_t;

  // Counter value seen on the TIMEOUT-th unacknowledged edge.
  localparam logic [15:0] LP_WAIT_TC = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wait;
  logic        r_is_write;
  logic        r_is_byte;
  logic [31:0] r_instruction;
  logic [31:0] r_load_data;
  logic        w_timeout;
  logic        w_misaligned;
  logic [7:0]  w_rd_byte;

  assign w_timeout    = (r_wait == LP_WAIT_TC);
  assign w_misaligned = (data_addr[1:0] != 2'b00);
  assign instruction  = r_instruction;
  assign load_data    = r_load_data;

  // Byte lane picked by the low address bits for lb.
  always_comb begin
    w_rd_byte = mem_rdata[7:0];
    case (data_addr[1:0])
      2'd0:    w_rd_byte = mem_rdata[7:0];
      2'd1:    w_rd_byte = mem_rdata[15:8];
      2'd2:    w_rd_byte = mem_rdata[23:16];
      default: w_rd_byte = mem_rdata[31:24];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-decoded bus/commit outputs.
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_sel   = 4'b0000;
    cpu_en    = 1'b0;
    bus_error = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_sel  = 4'b1111;
        mem_addr = {pc[31:2], 2'b00};
        if (mem_ack) begin
          w_next = S_EXEC;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_EXEC: begin
        // A store takes precedence when both read and write are decoded.
        if (write_mem) begin
          w_next = (!store_byte && w_misaligned) ? S_ERROR : S_DATA;
        end else if (read_mem) begin
          w_next = (!load_byte && w_misaligned) ? S_ERROR : S_DATA;
        end else begin
          w_next = S_COMMIT;
        end
      end
      S_DATA: begin
        mem_req  = 1'b1;
        mem_we   = r_is_write;
        mem_addr = {data_addr[31:2], 2'b00};
        if (r_is_byte) begin
          mem_sel   = 4'b0001 << data_addr[1:0];
          mem_wdata = {4{store_data[7:0]}};
        end else begin
          mem_sel   = 4'b1111;
          mem_wdata = store_data;
        end
        if (mem_ack) begin
          w_next = S_COMMIT;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_COMMIT: begin
        cpu_en = 1'b1;
        w_next = S_FETCH;
      end
      S_ERROR: begin
        bus_error = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Instruction/load capture, access attributes and ack wait counter.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wait        <= 16'h0;
      r_is_write    <= 1'b0;
      r_is_byte     <= 1'b0;
      r_instruction <= 32'h0000_0013;
      r_load_data   <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ack) begin
            r_instruction <= mem_rdata;
            r_wait        <= 16'h0;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        S_EXEC: begin
          // Decode flags are only valid now, so keep them for the DATA phase.
          r_is_write <= write_mem;
          r_is_byte  <= write_mem ? store_byte : load_byte;
          r_wait     <= 16'h0;
        end
        S_DATA: begin
          if (mem_ack) begin
            r_wait <= 16'h0;
            if (!r_is_write) begin
              r_load_data <= r_is_byte ? {{24{w_rd_byte[7]}}, w_rd_byte} : mem_rdata;
            end
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        default: begin
          r_wait <= 16'h0;
        end
      endcase
    end
  end

endmodule
